// File: rtl/led_pwm_fader.sv
// Per-channel PWM dimmer for a rotating LED pattern: lit channels jump to full
// brightness and decay by FADE_STEP every 2^FADE_DIV cycles once released.
module led_pwm_fader #(
  parameter int N_LEDS    = 6,
  parameter int PWM_BITS  = 8,
  parameter int FADE_DIV  = 16,
  parameter int FADE_STEP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] pat_n,
  input  logic              enable,
  output logic [N_LEDS-1:0] led_n,
  output logic              frame
);

  localparam logic [PWM_BITS-1:0] BRIGHT_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] BRIGHT_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] PWM_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);
  localparam logic [FADE_DIV-1:0] PRESC_MAX = {FADE_DIV{1'b1}};
  localparam logic [FADE_DIV-1:0] PRESC_ONE = {{(FADE_DIV-1){1'b0}}, 1'b1};

  logic [N_LEDS-1:0]   pat_q_r;
  logic [PWM_BITS-1:0] pwm_ctr_r;
  logic [FADE_DIV-1:0] presc_r;
  logic [PWM_BITS-1:0] bright_r     [N_LEDS];
  logic [PWM_BITS-1:0] shadow_r     [N_LEDS];
  logic [PWM_BITS-1:0] bright_nxt_s [N_LEDS];
  logic [PWM_BITS-1:0] shadow_nxt_s [N_LEDS];
  logic [N_LEDS-1:0]   led_nxt_s;
  logic                wrap_s;
  logic                tick_s;

  // Saturating fade step: never wraps below zero.
  function automatic logic [PWM_BITS-1:0] fade_dec(input logic [PWM_BITS-1:0] b);
    if (b > STEP) begin
      fade_dec = b - STEP;
    end else begin
      fade_dec = BRIGHT_ZERO;
    end
  endfunction

  assign wrap_s = (pwm_ctr_r == BRIGHT_MAX);
  assign tick_s = (presc_r == PRESC_MAX);

  // Next brightness, period-latched duty and pin level for every channel.
  always_comb begin
    led_nxt_s = {N_LEDS{1'b1}};
    for (int i = 0; i < N_LEDS; i++) begin
      bright_nxt_s[i] = bright_r[i];
      shadow_nxt_s[i] = shadow_r[i];
      if (!enable) begin
        bright_nxt_s[i] = BRIGHT_ZERO;
        shadow_nxt_s[i] = BRIGHT_ZERO;
        led_nxt_s[i]    = 1'b1;
      end else begin
        // A lit pattern bit wins over a coincident fade tick.
        if (!pat_q_r[i]) begin
          bright_nxt_s[i] = BRIGHT_MAX;
        end else if (tick_s) begin
          bright_nxt_s[i] = fade_dec(bright_r[i]);
        end else begin
          bright_nxt_s[i] = bright_r[i];
        end
        if (wrap_s) begin
          shadow_nxt_s[i] = bright_r[i];
        end else begin
          shadow_nxt_s[i] = shadow_r[i];
        end
        led_nxt_s[i] = (pwm_ctr_r < shadow_r[i]) ? 1'b0 : 1'b1;
      end
    end
  end

  // Counters, pattern register, per-channel state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_ctr_r <= BRIGHT_ZERO;
      presc_r   <= {FADE_DIV{1'b0}};
      pat_q_r   <= {N_LEDS{1'b1}};
      led_n     <= {N_LEDS{1'b1}};
      frame     <= 1'b0;
      for (int i = 0; i < N_LEDS; i++) begin
        bright_r[i] <= BRIGHT_ZERO;
        shadow_r[i] <= BRIGHT_ZERO;
      end
    end else begin
      pwm_ctr_r <= pwm_ctr_r + PWM_ONE;
      presc_r   <= presc_r + PRESC_ONE;
      pat_q_r   <= pat_n;
      led_n     <= led_nxt_s;
      frame     <= wrap_s;
      for (int i = 0; i < N_LEDS; i++) begin
        bright_r[i] <= bright_nxt_s[i];
        shadow_r[i] <= shadow_nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader (4 LEDs, 4-bit PWM, 8-cycle fade tick,
// step 4): a cycle model feeds a scoreboard, plus directed duty/latency checks.
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] pat_n = 4'b1111;
  logic [3:0] led_n;
  logic       frame;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [4:0] sb_q[$];
  logic [4:0] sb_exp;

  int         m_ctr = 0;
  int         m_pre = 0;
  logic [3:0] m_patq = 4'b1111;
  int         m_bright[4] = '{0, 0, 0, 0};
  int         m_shadow[4] = '{0, 0, 0, 0};

  led_pwm_fader #(
    .N_LEDS(4), .PWM_BITS(4), .FADE_DIV(3), .FADE_STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .pat_n(pat_n), .enable(enable),
    .led_n(led_n), .frame(frame)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_led();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = (!enable) ? 1'b1 : ((m_ctr < m_shadow[i]) ? 1'b0 : 1'b1);
    end
    return r;
  endfunction

  // Reference model: predicts the outputs of each edge and queues them.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ctr  <= 0;
      m_pre  <= 0;
      m_patq <= 4'b1111;
      for (int i = 0; i < 4; i++) begin
        m_bright[i] <= 0;
        m_shadow[i] <= 0;
      end
      sb_q.delete();
    end else begin
      sb_q.push_back({model_led(), (m_ctr == 15)});
      for (int i = 0; i < 4; i++) begin
        if (!enable) begin
          m_bright[i] <= 0;
          m_shadow[i] <= 0;
        end else begin
          if (!m_patq[i]) m_bright[i] <= 15;
          else if (m_pre == 7) m_bright[i] <= (m_bright[i] > 4) ? m_bright[i] - 4 : 0;
          if (m_ctr == 15) m_shadow[i] <= m_bright[i];
        end
      end
      m_ctr  <= (m_ctr + 1) % 16;
      m_pre  <= (m_pre + 1) % 8;
      m_patq <= pat_n;
    end
  end

  task automatic pulse_reset(input logic [3:0] pat, input logic en);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pat_n = pat;
    enable = en;
  endtask

  task automatic test_reset();
    int first_frame;
    rst = 1'b0;
    pat_n = 4'b0000;
    enable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++;
      if (led_n !== 4'b1111 || frame !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d: got led_n=%b frame=%b want 1111/0", c, led_n, frame);
      end
    end
    rst = 1'b1;
    first_frame = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL reset_sb c=%0d: scoreboard empty", c);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({led_n, frame} !== sb_exp) begin
          n_fail++;
          $display("FAIL reset_sb c=%0d: got %b want %b", c, {led_n, frame}, sb_exp);
        end
      end
      if (frame === 1'b1 && first_frame < 0) first_frame = c + 1;
    end
    n_chk++;
    if (first_frame != 16) begin
      n_fail++;
      $display("FAIL reset_first_frame: got cycle %0d want 16", first_frame);
    end
  endtask

  task automatic test_full_bright();
    int lows;
    pulse_reset(4'b1110, 1'b1);
    lows = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL full_sb c=%0d: scoreboard empty", c);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({led_n, frame} !== sb_exp) begin
          n_fail++;
          $display("FAIL full_sb c=%0d: got %b want %b", c, {led_n, frame}, sb_exp);
        end
      end
      n_chk++;
      if (led_n[3:1] !== 3'b111) begin
        n_fail++;
        $display("FAIL full_dark c=%0d: got led_n[3:1]=%b want 111", c, led_n[3:1]);
      end
      if (c >= 32 && c < 48 && led_n[0] === 1'b0) lows++;
    end
    n_chk++;
    if (lows != 15) begin
      n_fail++;
      $display("FAIL full_duty: got %0d lit cycles want 15", lows);
    end
  endtask

  task automatic test_fade_trail();
    int lows[7];
    int want[7];
    want = '{0, 0, 15, 11, 3, 0, 0};
    lows = '{0, 0, 0, 0, 0, 0, 0};
    pulse_reset(4'b1110, 1'b1);
    for (int c = 0; c < 112; c++) begin
      @(negedge clk);
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL fade_sb c=%0d: scoreboard empty", c);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({led_n, frame} !== sb_exp) begin
          n_fail++;
          $display("FAIL fade_sb c=%0d: got %b want %b", c, {led_n, frame}, sb_exp);
        end
      end
      if (led_n[0] === 1'b0) lows[c / 16]++;
      if (c == 36) pat_n = 4'b1111;
    end
    for (int p = 2; p < 7; p++) begin
      n_chk++;
      if (lows[p] != want[p]) begin
        n_fail++;
        $display("FAIL fade_duty period %0d: got %0d want %0d", p, lows[p], want[p]);
      end
    end
  endtask

  task automatic test_collision();
    int lows;
    pulse_reset(4'b1111, 1'b1);
    lows = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL coll_sb c=%0d: scoreboard empty", c);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({led_n, frame} !== sb_exp) begin
          n_fail++;
          $display("FAIL coll_sb c=%0d: got %b want %b", c, {led_n, frame}, sb_exp);
        end
      end
      if (c >= 32 && led_n[1] === 1'b0) lows++;
      // pat_q[1] is low only during edge 16, which is also a fade tick
      pat_n = (c == 13) ? 4'b1101 : 4'b1111;
    end
    n_chk++;
    if (lows != 11) begin
      n_fail++;
      $display("FAIL coll_duty: got %0d lit cycles want 11", lows);
    end
    for (int c = 0; c < 168; c++) begin
      @(negedge clk);
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL coll_sweep_sb c=%0d: scoreboard empty", c);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({led_n, frame} !== sb_exp) begin
          n_fail++;
          $display("FAIL coll_sweep_sb c=%0d: got %b want %b", c, {led_n, frame}, sb_exp);
        end
      end
      pat_n = ((c % 21) == 0) ? 4'b1101 : 4'b1111;
    end
  endtask

  task automatic test_enable();
    int frames;
    pulse_reset(4'b0000, 1'b1);
    frames = 0;
    for (int c = 0; c < 112; c++) begin
      @(negedge clk);
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL en_sb c=%0d: scoreboard empty", c);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({led_n, frame} !== sb_exp) begin
          n_fail++;
          $display("FAIL en_sb c=%0d: got %b want %b", c, {led_n, frame}, sb_exp);
        end
      end
      if (c == 41 || c == 95) begin
        n_chk++;
        if (led_n !== 4'b1111) begin
          n_fail++;
          $display("FAIL en_dark c=%0d: got %b want 1111", c, led_n);
        end
      end
      if (c == 96) begin
        n_chk++;
        if (led_n !== 4'b0000) begin
          n_fail++;
          $display("FAIL en_resume c=%0d: got %b want 0000", c, led_n);
        end
      end
      if (c > 40 && c <= 80 && frame === 1'b1) frames++;
      if (c == 40) enable = 1'b0;
      if (c == 80) enable = 1'b1;
    end
    n_chk++;
    if (frames != 3) begin
      n_fail++;
      $display("FAIL en_frames: got %0d frames while disabled want 3", frames);
    end
  endtask

  task automatic test_shadow_timing();
    int lows_cur;
    int lows_next;
    pulse_reset(4'b1111, 1'b1);
    lows_cur = 0;
    lows_next = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL shadow_sb c=%0d: scoreboard empty", c);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({led_n, frame} !== sb_exp) begin
          n_fail++;
          $display("FAIL shadow_sb c=%0d: got %b want %b", c, {led_n, frame}, sb_exp);
        end
      end
      if (c >= 32 && c < 48 && led_n[2] === 1'b0) lows_cur++;
      if (c >= 48 && led_n[2] === 1'b0) lows_next++;
      if (c == 36) pat_n = 4'b1011;
    end
    n_chk++;
    if (lows_cur != 0) begin
      n_fail++;
      $display("FAIL shadow_cur: got %0d lit cycles want 0", lows_cur);
    end
    n_chk++;
    if (lows_next != 15) begin
      n_fail++;
      $display("FAIL shadow_next: got %0d lit cycles want 15", lows_next);
    end
  endtask

  initial begin
    test_reset();
    test_full_bright();
    test_fade_trail();
    test_collision();
    test_enable();
    test_shadow_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
